// File: rtl/ts_pkg.sv
// Shared constants and state encoding for the TS-to-OTT-RAM write path.
package ts_pkg;

   localparam int TS_PKT_WORDS = 47;
   localparam int LANES        = 16;
   localparam int OTT_ADDR_W   = 11;

   typedef enum logic [1:0] {
      WAIT_SOP = 2'd0,
      FILL     = 2'd1,
      FULL     = 2'd2
   } wr_state_e;

endpackage

// File: rtl/edge_rise.sv
// Registered rising-edge detector: pulses for one cycle when sig_i goes 0 -> 1.
module edge_rise (
   input  logic clk,
   input  logic rst,
   input  logic sig_i,
   output logic rise_o
);

   logic sig_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sig_q <= 1'b0;
      end else begin
         sig_q <= sig_i;
      end
   end

   assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/ott_ram_wr.sv
// Packs a 32-bit TS word stream into 512-bit OTT RAM words, one frame at a time,
// holding the frame until the read side releases it with a rising clear edge.
module ott_ram_wr
   import ts_pkg::*;
#(
   parameter int FRAME_WORDS = 2048,
   parameter int ADDR_W      = OTT_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       ts_din,
   input  logic              ts_en,
   input  logic              ts_sop,
   input  logic              ott_ram_clear,
   output logic              ott_wea,
   output logic [ADDR_W-1:0] ott_addra,
   output logic [511:0]      ott_dina,
   output logic              ts_ram_valid,
   output logic [15:0]       drop_cnt,
   output logic              sync_err
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);
   localparam logic [5:0]        PKT_LAST  = 6'(TS_PKT_WORDS - 1);
   localparam logic [3:0]        LAST_LANE = 4'(LANES - 1);

   wr_state_e         state_q, state_d;
   logic [3:0]        lane_q, lane_d;
   logic [5:0]        pkt_q, pkt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [511:0]      data_q, data_d;
   logic              wea_q, wea_d;
   logic              valid_q, valid_d;
   logic [15:0]       drop_q, drop_d;
   logic              err_q, err_d;
   logic              clear_edge;
   logic              final_write;
   logic              accept;

   edge_rise u_clear_edge (
      .clk    (clk),
      .rst    (rst),
      .sig_i  (ott_ram_clear),
      .rise_o (clear_edge)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= WAIT_SOP;
         lane_q  <= '0;
         pkt_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         wea_q   <= 1'b0;
         valid_q <= 1'b0;
         drop_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         lane_q  <= lane_d;
         pkt_q   <= pkt_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         wea_q   <= wea_d;
         valid_q <= valid_d;
         drop_q  <= drop_d;
         err_q   <= err_d;
      end
   end

   // The frame is complete from the cycle its last write is on the bus, so a word
   // arriving then already counts as excess and a clear edge there still aborts.
   always_comb begin
      final_write = (state_q == FILL) && wea_q && (addr_q == LAST_ADDR);
      accept      = ts_en && (((state_q == WAIT_SOP) && ts_sop) ||
                              ((state_q == FILL) && !final_write && !clear_edge));
   end

   always_comb begin
      state_d = state_q;
      lane_d  = lane_q;
      pkt_d   = pkt_q;
      addr_d  = addr_q;
      data_d  = data_q;
      wea_d   = 1'b0;
      valid_d = valid_q;
      drop_d  = drop_q;
      err_d   = 1'b0;

      if (accept) begin
         data_d[{lane_q, 5'b0} +: 32] = ts_din;
         lane_d = lane_q + 4'd1;
         wea_d  = (lane_q == LAST_LANE);
         if (ts_sop) begin
            err_d = (state_q == FILL) && (pkt_q != 6'd0);
            pkt_d = 6'd1;
         end else begin
            err_d = (pkt_q == 6'd0);
            pkt_d = (pkt_q == PKT_LAST) ? 6'd0 : pkt_q + 6'd1;
         end
      end

      if (ts_en && ((state_q == FULL) || final_write) && (drop_q != 16'hFFFF)) begin
         drop_d = drop_q + 16'd1;
      end

      case (state_q)
         WAIT_SOP: begin
            if (accept) begin
               state_d = FILL;
            end
         end
         FILL: begin
            if (clear_edge) begin
               state_d = WAIT_SOP;
               lane_d  = '0;
               pkt_d   = '0;
               addr_d  = '0;
            end else if (wea_q) begin
               addr_d = addr_q + 1'b1;
               if (final_write) begin
                  state_d = FULL;
                  valid_d = 1'b1;
                  lane_d  = '0;
                  pkt_d   = '0;
               end
            end
         end
         FULL: begin
            if (clear_edge) begin
               state_d = WAIT_SOP;
               valid_d = 1'b0;
               lane_d  = '0;
               pkt_d   = '0;
               addr_d  = '0;
            end
         end
         default: begin
            state_d = WAIT_SOP;
         end
      endcase
   end

   assign ott_wea      = wea_q;
   assign ott_addra    = addr_q;
   assign ott_dina     = data_q;
   assign ts_ram_valid = valid_q;
   assign drop_cnt     = drop_q;
   assign sync_err     = err_q;

endmodule
